// File: rtl/qtree_match_cfg_pkg.sv
// Shared types for the quadtree match-stage rule manager: command ops, response status, RAM word.
// Slot width helper keeps a 1-way bank at a 1-bit slot index.
package qtree_match_cfg_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_CLEAR  = 2'd3
  } cfg_op_t;

  typedef enum logic [1:0] {
    STS_OK        = 2'd0,
    STS_FULL      = 2'd1,
    STS_DUP       = 2'd2,
    STS_NOT_FOUND = 2'd3
  } cfg_status_t;

  localparam int MATCH_VALUE_W = 16;

  typedef struct packed {
    logic                     en;
    logic [MATCH_VALUE_W-1:0] value;
  } match_ram_data_t;

  function automatic int slot_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/qstage_ctrl_if.sv
// Write port into the D_CNT-way match RAM bank; wr_data is {en, value}, sel picks the ways written.
interface qstage_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int D_CNT  = 4
);
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W:0]   wr_data;
  logic              wr_en;
  logic [D_CNT-1:0]  sel;

  modport master (output wr_addr, output wr_data, output wr_en, output sel);
  modport slave  (input wr_addr, input wr_data, input wr_en, input sel);
endinterface

// File: rtl/qtree_free_slot_pick.sv
// Combinational lowest-index free-way finder over one row of the occupancy map.
module qtree_free_slot_pick #(
  parameter int D_CNT  = 4,
  parameter int SLOT_W = 2
) (
  input  logic [D_CNT-1:0]  occ,
  output logic [SLOT_W-1:0] slot,
  output logic              any_free
);

  // Scanning downward lets the lowest free way overwrite any higher one.
  always_comb begin
    slot     = '0;
    any_free = 1'b0;
    for (int w = D_CNT - 1; w >= 0; w--) begin
      if (!occ[w]) begin
        slot     = SLOT_W'(w);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qtree_match_cfg.sv
// Rule manager for one quadtree match stage: INSERT/DELETE/CLEAR into a D_CNT-way RAM with shadow occupancy.
// Optional duplicate detection under QTREE_MATCH_CFG_DUP_CHECK_EN.
module qtree_match_cfg
  import qtree_match_cfg_pkg::*;
#(
  parameter int IN_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int D_CNT         = 4,
  parameter int SLOT_W        = slot_width(D_CNT)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  cfg_op_t                  cmd_op_i,
  input  logic [IN_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]    cmd_data_i,
  input  logic [SLOT_W-1:0]        cmd_slot_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output cfg_status_t              resp_status_o,
  output logic [SLOT_W-1:0]        resp_slot_o,
  output logic                     busy_o,
  qstage_ctrl_if.master            ctrl_if
);

  localparam int ROWS = 2 ** IN_ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4,
    S_SWEEP = 3'd5
  } fsm_t;

  fsm_t state, state_nxt;

  logic [IN_ADDR_WIDTH-1:0] sweep_row;
  logic                     sweep_last;
  cfg_op_t                  op_q;
  logic [IN_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [SLOT_W-1:0]        slot_q;
  cfg_status_t              status_q;
  logic [SLOT_W-1:0]        resp_slot_q;
  logic [D_CNT-1:0]         occ [ROWS];

  logic [D_CNT-1:0]  row_occ;
  logic [SLOT_W-1:0] free_slot;
  logic              any_free;
  logic              del_hit;
  logic              dup_hit;
  logic [SLOT_W-1:0] dup_slot;
  cfg_status_t       exec_status;
  logic [SLOT_W-1:0] exec_slot;
  logic              exec_write;

  assign sweep_last = (sweep_row == IN_ADDR_WIDTH'(ROWS - 1));
  assign row_occ    = occ[addr_q];
  assign del_hit    = (int'(slot_q) < D_CNT) && row_occ[slot_q];

  qtree_free_slot_pick #(
    .D_CNT  (D_CNT),
    .SLOT_W (SLOT_W)
  ) u_pick (
    .occ      (row_occ),
    .slot     (free_slot),
    .any_free (any_free)
  );

`ifdef QTREE_MATCH_CFG_DUP_CHECK_EN
  // Stale values are harmless: they are only compared where the occupancy bit is set.
  logic [DATA_WIDTH-1:0] val_q [ROWS][D_CNT];

  always_ff @(posedge clk_i) begin
    if (state == S_WRITE && op_q == OP_INSERT) begin
      val_q[addr_q][slot_q] <= data_q;
    end
  end

  always_comb begin
    dup_hit  = 1'b0;
    dup_slot = '0;
    for (int w = D_CNT - 1; w >= 0; w--) begin
      if (row_occ[w] && (val_q[addr_q][w] == data_q)) begin
        dup_hit  = 1'b1;
        dup_slot = SLOT_W'(w);
      end
    end
  end
`else
  assign dup_hit  = 1'b0;
  assign dup_slot = '0;
`endif

  always_comb begin
    exec_status = STS_OK;
    exec_slot   = '0;
    exec_write  = 1'b0;
    case (op_q)
      OP_INSERT: begin
        if (!any_free) begin
          exec_status = STS_FULL;
        end else if (dup_hit) begin
          exec_status = STS_DUP;
          exec_slot   = dup_slot;
        end else begin
          exec_slot  = free_slot;
          exec_write = 1'b1;
        end
      end
      OP_DELETE: begin
        if (del_hit) begin
          exec_slot  = slot_q;
          exec_write = 1'b1;
        end else begin
          exec_status = STS_NOT_FOUND;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    ctrl_if.wr_en   = 1'b0;
    ctrl_if.sel     = '0;
    ctrl_if.wr_data = '0;
    ctrl_if.wr_addr = '0;
    case (state)
      S_INIT, S_SWEEP: begin
        // Held off while rst_i is asserted so the bank is never written during reset.
        ctrl_if.wr_en                         = !rst_i;
        ctrl_if.sel                           = rst_i ? '0 : '1;
        ctrl_if.wr_addr[IN_ADDR_WIDTH-1:0]    = sweep_row;
        if (sweep_last) begin
          state_nxt = (state == S_INIT) ? S_IDLE : S_RESP;
        end
      end
      S_IDLE: begin
        if (cmd_valid_i) begin
          case (cmd_op_i)
            OP_INSERT, OP_DELETE: state_nxt = S_EXEC;
            OP_CLEAR:             state_nxt = S_SWEEP;
            default:              state_nxt = S_IDLE;
          endcase
        end
      end
      S_EXEC: begin
        state_nxt = exec_write ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        ctrl_if.wr_en                      = 1'b1;
        ctrl_if.wr_addr[IN_ADDR_WIDTH-1:0] = addr_q;
        ctrl_if.wr_data                    = (op_q == OP_INSERT) ? {1'b1, data_q} : '0;
        for (int w = 0; w < D_CNT; w++) begin
          ctrl_if.sel[w] = (slot_q == SLOT_W'(w));
        end
        state_nxt = S_RESP;
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sweep_row   <= '0;
      op_q        <= OP_NOP;
      addr_q      <= '0;
      data_q      <= '0;
      slot_q      <= '0;
      status_q    <= STS_OK;
      resp_slot_q <= '0;
      for (int r = 0; r < ROWS; r++) begin
        occ[r] <= '0;
      end
    end else begin
      case (state)
        S_INIT, S_SWEEP: begin
          occ[sweep_row] <= '0;
          sweep_row      <= sweep_last ? '0 : sweep_row + 1'b1;
          if (state == S_SWEEP && sweep_last) begin
            status_q    <= STS_OK;
            resp_slot_q <= '0;
          end
        end
        S_IDLE: begin
          if (cmd_valid_i) begin
            op_q   <= cmd_op_i;
            addr_q <= cmd_addr_i;
            data_q <= cmd_data_i;
            slot_q <= cmd_slot_i;
          end
        end
        S_EXEC: begin
          status_q    <= exec_status;
          resp_slot_q <= exec_slot;
          slot_q      <= exec_slot;
        end
        S_WRITE: begin
          occ[addr_q][slot_q] <= (op_q == OP_INSERT);
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready_o   = (state == S_IDLE);
  assign resp_valid_o  = (state == S_RESP);
  assign resp_status_o = status_q;
  assign resp_slot_o   = resp_slot_q;
  assign busy_o        = (state == S_INIT) || (state == S_SWEEP);

endmodule

// File: tb/tb_qtree_match_cfg.sv
// Randomized bench for qtree_match_cfg: behavioural rule-table model plus a RAM mirror fed by the write port.
module tb_qtree_match_cfg;
  import qtree_match_cfg_pkg::*;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  cfg_op_t     cmd_op;
  logic [3:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic [1:0]  cmd_slot;
  logic        resp_valid;
  logic        resp_ready;
  cfg_status_t resp_status;
  logic [1:0]  resp_slot;
  logic        busy;

  qstage_ctrl_if #(.ADDR_W(8), .DATA_W(16), .D_CNT(4)) ctrl_bus ();

  qtree_match_cfg #(
    .IN_ADDR_WIDTH (4),
    .DATA_WIDTH    (16),
    .D_CNT         (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_op_i      (cmd_op),
    .cmd_addr_i    (cmd_addr),
    .cmd_data_i    (cmd_data),
    .cmd_slot_i    (cmd_slot),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_status_o (resp_status),
    .resp_slot_o   (resp_slot),
    .busy_o        (busy),
    .ctrl_if       (ctrl_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int bad_sweep = 0;
  int bad_write = 0;
  int bad_addr  = 0;

  // Rule table as the host sees it, and what the RAM holds according to the write port.
  bit              m_occ [16][4];
  logic [15:0]     m_val [16][4];
  match_ram_data_t mirror [16][4];

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ctrl_bus.wr_en) begin
      wr_cnt++;
      if (ctrl_bus.wr_addr[7:4] != 4'h0) bad_addr++;
      if (busy && (ctrl_bus.sel != 4'hF || ctrl_bus.wr_data != 17'h0)) bad_sweep++;
      if (!busy && $countones(ctrl_bus.sel) != 1) bad_write++;
      for (int g = 0; g < 4; g++) begin
        if (ctrl_bus.sel[g]) mirror[ctrl_bus.wr_addr[3:0]][g] = ctrl_bus.wr_data;
      end
    end
  end

  function automatic logic [127:0] mirror_row(input logic [3:0] r);
    logic [127:0] v = '0;
    for (int w = 0; w < 4; w++) v[w*17 +: 17] = mirror[r][w];
    return v;
  endfunction

  function automatic logic [127:0] model_row(input logic [3:0] r);
    logic [127:0] v = '0;
    for (int w = 0; w < 4; w++) v[w*17 +: 17] = m_occ[r][w] ? {1'b1, m_val[r][w]} : 17'h0;
    return v;
  endfunction

  function automatic bit lookup(input logic [3:0] r, input logic [15:0] d);
    bit hit = 1'b0;
    for (int w = 0; w < 4; w++) if (mirror[r][w].en && mirror[r][w].value == d) hit = 1'b1;
    return hit;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 16; r++)
      for (int w = 0; w < 4; w++) begin
        m_occ[r][w] = 1'b0;
        m_val[r][w] = 16'h0;
      end
  endtask

  task automatic init_check(input string tag);
    int busy_n = 0;
    wr_cnt    = 0;
    bad_sweep = 0;
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      else break;
    end
    check({tag, "_busy_cycles"}, busy_n, 16);
    check({tag, "_wr_pulses"}, wr_cnt, 16);
    check({tag, "_sweep_fmt"}, bad_sweep, 0);
    check({tag, "_ready"}, cmd_ready, 1'b1);
  endtask

  task automatic do_cmd(input cfg_op_t op, input logic [3:0] a, input logic [15:0] d,
                        input logic [1:0] s, input int hold);
    cfg_status_t exp_st;
    cfg_status_t st0;
    logic [1:0]  exp_slot;
    logic [1:0]  sl0;
    int exp_lat, exp_wr, first_free, dup, w0, w_hold, lat;
    bit got, stable;
    exp_st = STS_OK; exp_slot = 2'd0; exp_lat = 3; exp_wr = 1;
    first_free = -1; dup = -1;
    case (op)
      OP_INSERT: begin
        for (int w = 0; w < 4; w++) begin
          if (m_occ[a][w]) begin
            if (dup < 0 && m_val[a][w] == d) dup = w;
          end else if (first_free < 0) first_free = w;
        end
        if (first_free < 0) begin
          exp_st = STS_FULL; exp_lat = 2; exp_wr = 0;
        end
`ifdef QTREE_MATCH_CFG_DUP_CHECK_EN
        else if (dup >= 0) begin
          exp_st = STS_DUP; exp_slot = 2'(dup); exp_lat = 2; exp_wr = 0;
        end
`endif
        else begin
          exp_slot = 2'(first_free);
          m_occ[a][first_free] = 1'b1;
          m_val[a][first_free] = d;
        end
      end
      OP_DELETE: begin
        if (m_occ[a][s]) begin
          exp_slot = s;
          m_occ[a][s] = 1'b0;
          m_val[a][s] = 16'h0;
        end else begin
          exp_st = STS_NOT_FOUND; exp_lat = 2; exp_wr = 0;
        end
      end
      OP_CLEAR: begin
        exp_lat = 17; exp_wr = 16;
        model_clear();
      end
      default: begin
        exp_lat = 0; exp_wr = 0;
      end
    endcase

    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_slot = s;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) got = 1'b1;
    end
    if (!got) begin
      check("handshake_timeout", 1'b0, 1'b1);
      cmd_valid = 1'b0;
      return;
    end
    w0 = wr_cnt;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = cfg_op_t'($urandom_range(0, 3));
    cmd_addr  = 4'($urandom); cmd_data = 16'($urandom); cmd_slot = 2'($urandom);
    if (hold == 0 && $urandom_range(0, 1) == 1) resp_ready = 1'b1;

    if (op == OP_NOP) begin
      got = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (resp_valid) got = 1'b1;
        if (k == 1) check("nop_ready", cmd_ready, 1'b1);
      end
      check("nop_no_resp", got, 1'b0);
      check("nop_writes", wr_cnt - w0, 0);
      resp_ready = 1'b0;
      return;
    end

    got = 1'b0; lat = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        lat = k;
      end
    end
    if (!got) begin
      check("resp_timeout", 1'b0, 1'b1);
      resp_ready = 1'b0;
      return;
    end
    check("resp_status", resp_status, exp_st);
    check("resp_slot", resp_slot, exp_slot);
    check("resp_latency", lat, exp_lat);

    if (hold > 0) begin
      stable = 1'b1;
      st0 = resp_status; sl0 = resp_slot; w_hold = wr_cnt;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (!resp_valid || resp_status != st0 || resp_slot != sl0 || cmd_ready) stable = 1'b0;
      end
      if (wr_cnt != w_hold) stable = 1'b0;
      check("resp_hold", stable, 1'b1);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check("write_count", wr_cnt - w0, exp_wr);
    check("row_contents", mirror_row(a), model_row(a));
  endtask

  function automatic logic [3:0] rand_row();
    case ($urandom_range(0, 4))
      0: return 4'd0;
      1: return 4'd1;
      2: return 4'd2;
      3: return 4'd3;
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [15:0] rand_val();
    case ($urandom_range(0, 3))
      0: return 16'hABCD;
      1: return 16'h1234;
      2: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r;
    cfg_op_t op;
    bit got;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_addr = '0; cmd_data = '0;
    cmd_slot = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_status", resp_status, STS_OK);
    check("rst_slot", resp_slot, 2'd0);
    check("rst_wr_en", ctrl_bus.wr_en, 1'b0);
    check("rst_sel", ctrl_bus.sel, 4'h0);
    check("rst_busy", busy, 1'b1);
    init_check("init");

    for (int i = 0; i < 5; i++) do_cmd(OP_INSERT, 4'd3, 16'hABCD, 2'd0, 0);
    check("lookup_before_clear", lookup(4'd3, 16'hABCD), 1'b1);
    do_cmd(OP_DELETE, 4'd3, 16'h0, 2'd2, 0);
    do_cmd(OP_INSERT, 4'd3, 16'h0001, 2'd0, 0);
    do_cmd(OP_DELETE, 4'd7, 16'h0, 2'd0, 0);
    do_cmd(OP_INSERT, 4'd5, 16'h1234, 2'd0, 0);
    do_cmd(OP_INSERT, 4'd5, 16'h1234, 2'd0, 0);
    do_cmd(OP_INSERT, 4'd15, 16'hBEEF, 2'd0, 10);
    do_cmd(OP_DELETE, 4'd15, 16'h0, 2'd0, 10);
    do_cmd(OP_NOP, 4'd2, 16'h5555, 2'd1, 0);
    do_cmd(OP_CLEAR, 4'd3, 16'h0, 2'd0, 0);
    check("lookup_after_clear", lookup(4'd3, 16'hABCD), 1'b0);
    check("last_row_cleared", mirror_row(4'd15), 128'h0);

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      op = OP_INSERT;
      else if (r < 85) op = OP_DELETE;
      else if (r < 93) op = OP_NOP;
      else             op = OP_CLEAR;
      do_cmd(op, rand_row(), rand_val(), 2'($urandom),
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 6)) : 0);
    end

    // Reset landing in the WRITE cycle of an insert into an empty row.
    do_cmd(OP_CLEAR, 4'd9, 16'h0, 2'd0, 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_op = OP_INSERT; cmd_addr = 4'd9; cmd_data = 16'hC0DE; cmd_slot = 2'd0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) got = 1'b1;
    end
    check("rstw_handshake", got, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstw_write_cycle", ctrl_bus.wr_en, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rstw_abandon", ctrl_bus.wr_en, 1'b0);
    check("rstw_busy", busy, 1'b1);
    check("rstw_ready", cmd_ready, 1'b0);
    repeat (2) @(posedge clk);
    init_check("reinit");
    check("rstw_row_empty", mirror_row(4'd9), 128'h0);
    do_cmd(OP_INSERT, 4'd9, 16'hC0DE, 2'd0, 0);

    check("write_sel_onehot", bad_write, 0);
    check("wr_addr_zero_ext", bad_addr, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
